pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_if.sv | 36 +++
 rtl/pipelined_adder.sv | 143 ++++++++++++++
 tb/tb_pipelined_adder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_if
// Description : Operand/result handshake bundle for pipelined_adder.
//               master = producer/consumer side, slave = adder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int WIDTH = 16
) ();
    // Operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             sub;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    modport master (
        output in_valid, a, b, carryin, sub, out_ready,
        input  in_ready, out_valid, sum, carryout, overflow
    );

    modport slave (
        input  in_valid, a, b, carryin, sub, out_ready,
        output in_ready, out_valid, sum, carryout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : Carry-pipelined adder/subtractor. The operands are split into
//               SEG-bit segments; stage k adds segment k using the carry
//               registered by stage k-1. Not-yet-used operand bits travel in
//               skew registers, finished sum bits travel in deskew registers,
//               so the full result leaves the last stage aligned.
//               Valid/ready flow control: the whole pipe advances when the
//               output slot is empty or being consumed, otherwise it freezes.
//               WIDTH must be an integer multiple of SEG.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pipelined_adder_if.slave bus
);

    localparam int STAGES = WIDTH / SEG;

    // ------------------------------------------------------------------
    // Flow control and operand conditioning
    // ------------------------------------------------------------------
    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // The pipe moves as one: it can shift whenever the output slot frees up.
    assign w_advance    = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = w_advance;

    // Subtraction is a + ~b + 1; the external carry only matters when adding.
    assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_eff = bus.sub | bus.carryin;

    // ------------------------------------------------------------------
    // Segment stages
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still pending after this stage has consumed its segment
        localparam int c_UW = WIDTH - (k + 1) * SEG;

        logic                   w_vin;
        logic                   w_cin;
        logic [SEG-1:0]         w_sa;
        logic [SEG-1:0]         w_sb;
        logic [SEG:0]           w_add;
        logic [(k+1)*SEG-1:0]   w_res_next;

        logic                   r_valid;
        logic                   r_carry;
        logic [(k+1)*SEG-1:0]   r_res;

        if (k == 0) begin : g_head
            // First stage takes its segment straight from the accepted operands
            assign w_vin      = bus.in_valid;
            assign w_cin      = w_cin_eff;
            assign w_sa       = bus.a[SEG-1:0];
            assign w_sb       = w_b_eff[SEG-1:0];
            assign w_res_next = w_add[SEG-1:0];
        end else begin : g_body
            // Later stages take the low segment of the previous stage's skew data
            assign w_vin      = g_stage[k-1].r_valid;
            assign w_cin      = g_stage[k-1].r_carry;
            assign w_sa       = g_stage[k-1].g_skew.r_ua[SEG-1:0];
            assign w_sb       = g_stage[k-1].g_skew.r_ub[SEG-1:0];
            assign w_res_next = {w_add[SEG-1:0], g_stage[k-1].r_res};
        end

        // Segment adder with carry in and carry out
        assign w_add = {1'b0, w_sa} + {1'b0, w_sb} + {{SEG{1'b0}}, w_cin};

        // Stage valid, carry and deskewed partial sum; frozen while stalled
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_res   <= '0;
            end else if (w_advance) begin
                r_valid <= w_vin;
                r_carry <= w_add[SEG];
                r_res   <= w_res_next;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [c_UW-1:0] w_ua_next;
            logic [c_UW-1:0] w_ub_next;
            logic [c_UW-1:0] r_ua;
            logic [c_UW-1:0] r_ub;

            if (k == 0) begin : g_src_in
                assign w_ua_next = bus.a[WIDTH-1:SEG];
                assign w_ub_next = w_b_eff[WIDTH-1:SEG];
            end else begin : g_src_prev
                assign w_ua_next = g_stage[k-1].g_skew.r_ua[c_UW+SEG-1:SEG];
                assign w_ub_next = g_stage[k-1].g_skew.r_ub[c_UW+SEG-1:SEG];
            end

            // Upper operand bits ride along until their stage is reached
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ua <= '0;
                    r_ub <= '0;
                end else if (w_advance) begin
                    r_ua <= w_ua_next;
                    r_ub <= w_ub_next;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic w_ovf;
            logic r_ovf;

            // Carry into the MSB is recovered as sum ^ a ^ b at that bit
            assign w_ovf = w_add[SEG] ^ (w_add[SEG-1] ^ w_sa[SEG-1] ^ w_sb[SEG-1]);

            // Overflow flag registered alongside the final carry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ovf <= 1'b0;
                end else if (w_advance) begin
                    r_ovf <= w_ovf;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result presentation
    // ------------------------------------------------------------------
    assign bus.out_valid = g_stage[STAGES-1].r_valid;
    assign bus.sum       = g_stage[STAGES-1].r_res;
    assign bus.carryout  = g_stage[STAGES-1].r_carry;
    assign bus.overflow  = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Self-checking bench for pipelined_adder. Directed steps on a
//               16/4 instance, then random traffic on 8/8, 16/4 and 32/8
//               instances, all checked through per-instance scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    logic clk;
    logic reset;

    int total;
    int bad;
    int n_out16;
    logic acc16;

    logic [33:0] q16[$];
    logic [33:0] q8[$];
    logic [33:0] q32[$];

    pipelined_adder_if #(.WIDTH(16)) if16 ();
    pipelined_adder_if #(.WIDTH(8))  if8  ();
    pipelined_adder_if #(.WIDTH(32)) if32 ();

    pipelined_adder #(.WIDTH(16), .SEG(4)) u_dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
    pipelined_adder #(.WIDTH(8),  .SEG(8)) u_dut8  (.clk(clk), .reset(reset), .bus(if8.slave));
    pipelined_adder #(.WIDTH(32), .SEG(8)) u_dut32 (.clk(clk), .reset(reset), .bus(if32.slave));

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-width reference: returns {overflow, carryout, sum zero-extended to 32}
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sb);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] bm;
        logic [32:0] full;
        logic        ci;
        logic        cout;
        logic        ctop;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am   = a & mask;
        bm   = sb ? (~b & mask) : (b & mask);
        ci   = sb ? 1'b1 : cin;
        full = {1'b0, am} + {1'b0, bm} + {32'h0, ci};
        cout = full[w];
        ctop = full[w-1] ^ am[w-1] ^ bm[w-1];
        return {cout ^ ctop, cout, full[31:0] & mask};
    endfunction

    function automatic logic [33:0] obs16();
        return {if16.overflow, if16.carryout, 16'h0, if16.sum};
    endfunction

    function automatic logic [33:0] obs8();
        return {if8.overflow, if8.carryout, 24'h0, if8.sum};
    endfunction

    function automatic logic [33:0] obs32();
        return {if32.overflow, if32.carryout, if32.sum};
    endfunction

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pop one expected result for an output being consumed; an empty queue is a failure
    task automatic sb_pop(input string tag, inout logic [33:0] q[$], input logic [33:0] obs);
        logic [33:0] exp;
        total++;
        assert (q.size() != 0) else begin
            bad++;
            $error("FAIL %s_extra observed=%h expected=none", tag, obs);
        end
        if (q.size() != 0) begin
            exp = q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // One clock: record handshakes just before the edge, then advance to edge+1
    task automatic clk_step();
        #1;
        acc16 = if16.in_valid && if16.in_ready;
        if (acc16)
            q16.push_back(model(16, {16'h0, if16.a}, {16'h0, if16.b}, if16.carryin, if16.sub));
        if (if8.in_valid && if8.in_ready)
            q8.push_back(model(8, {24'h0, if8.a}, {24'h0, if8.b}, if8.carryin, if8.sub));
        if (if32.in_valid && if32.in_ready)
            q32.push_back(model(32, if32.a, if32.b, if32.carryin, if32.sub));
        if (if16.out_valid && if16.out_ready) begin
            sb_pop("sb16", q16, obs16());
            n_out16++;
        end
        if (if8.out_valid && if8.out_ready)
            sb_pop("sb8", q8, obs8());
        if (if32.out_valid && if32.out_ready)
            sb_pop("sb32", q32, obs32());
        @(posedge clk);
        #1;
    endtask

    // Send one operand set on the 16-bit instance, check latency and the literal result
    task automatic send_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sb, input logic [33:0] exp);
        int n;
        if16.a         = a;
        if16.b         = b;
        if16.carryin   = cin;
        if16.sub       = sb;
        if16.in_valid  = 1'b1;
        if16.out_ready = 1'b1;
        clk_step();
        check_int({tag, "_acc"}, int'(acc16), 1);
        if16.in_valid = 1'b0;
        if16.a        = 16'hDEAD;
        if16.b        = 16'hBEEF;
        if16.sub      = ~sb;
        n = 1;
        while (!if16.out_valid && n < 20) begin
            clk_step();
            n++;
        end
        check_int({tag, "_lat"}, n, 4);
        check(tag, obs16(), exp);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] t;
        logic [33:0] held;
        logic        seen;
        int          sent;
        int          base;

        total   = 0;
        bad     = 0;
        n_out16 = 0;
        acc16   = 1'b0;
        reset   = 1'b1;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.carryin = 1'b0; if16.sub = 1'b0; if16.out_ready = 1'b1;
        if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.carryin  = 1'b0; if8.sub  = 1'b0; if8.out_ready  = 1'b1;
        if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.carryin = 1'b0; if32.sub = 1'b0; if32.out_ready = 1'b1;

        // Reset state, before any clock edge
        #2;
        check_int("rst_out_valid", int'(if16.out_valid), 0);
        check("rst_result", obs16(), 34'h0);
        check_int("rst_in_ready", int'(if16.in_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_int("post_rst_in_ready", int'(if16.in_ready), 1);

        // Directed arithmetic corners; each result is then consumed via the scoreboard
        send_check("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        clk_step();
        send_check("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000_8000});
        clk_step();
        send_check("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'h0000_FFFE});
        clk_step();
        send_check("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h0000_7FFF});
        clk_step();

        // Stall a visible result, then reset asynchronously between edges
        send_check("add_cin", 16'h1234, 16'h0FCB, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0000_2200});
        if16.out_ready = 1'b0;
        clk_step();
        check("stall_hold_single", obs16(), {1'b0, 1'b0, 32'h0000_2200});
        reset = 1'b1;
        #1;
        check_int("async_rst_valid", int'(if16.out_valid), 0);
        check("async_rst_result", obs16(), 34'h0);
        check_int("async_rst_in_ready", int'(if16.in_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q16.delete();
        if16.out_ready = 1'b1;

        // Three in flight, one-cycle reset before any emerges: nothing may come out
        for (int i = 0; i < 3; i++) begin
            if16.a        = 16'h0100 * 16'(i + 1);
            if16.b        = 16'h0011;
            if16.sub      = 1'b0;
            if16.in_valid = 1'b1;
            clk_step();
        end
        if16.in_valid = 1'b0;
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        q16.delete();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clk_step();
            seen = seen | if16.out_valid;
        end
        check_int("flush_no_output", int'(seen), 0);
        send_check("after_flush", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        clk_step();

        // Eight back-to-back adds, output stalled on cycles 6-8
        sent = 0;
        base = n_out16;
        held = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            t = 32'h9E37_79B9 * 32'(sent + 1);
            if16.a         = t[15:0];
            if16.b         = t[31:16];
            if16.carryin   = t[7];
            if16.sub       = 1'b0;
            if16.in_valid  = (sent < 8);
            if16.out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            if (cyc >= 6 && cyc <= 8) begin
                check_int("stall_in_ready", int'(if16.in_ready), 0);
                check_int("stall_out_valid", int'(if16.out_valid), 1);
                if (cyc == 6)
                    held = obs16();
                else
                    check("stall_hold", obs16(), held);
            end
            clk_step();
            if (acc16) sent++;
        end
        if16.in_valid = 1'b0;
        check_int("stream_accepted", sent, 8);
        check_int("stream_results", n_out16 - base, 8);
        check_int("stream_drained", q16.size(), 0);

        // Random traffic with bubbles and back-pressure on all three instances
        for (int cyc = 0; cyc < 800; cyc++) begin
            r = $urandom();
            if16.a = r[15:0];
            if16.b = r[31:16];
            if8.a  = r[7:0];
            if8.b  = r[23:16];
            r = $urandom();
            if16.carryin = r[0];
            if16.sub     = r[1];
            if8.carryin  = r[2];
            if8.sub      = r[3];
            if32.carryin = r[4];
            if32.sub     = r[5];
            if (r[10:8] == 3'd0) begin
                if16.a = 16'hFFFF;
                if8.b  = 8'h80;
            end
            if32.a = $urandom();
            if32.b = $urandom();
            if (r[13:11] == 3'd0) if32.a = 32'h7FFF_FFFF;
            if16.in_valid  = ($urandom_range(9, 0) < 7);
            if8.in_valid   = ($urandom_range(9, 0) < 6);
            if32.in_valid  = ($urandom_range(9, 0) < 7);
            if16.out_ready = ($urandom_range(9, 0) < 7);
            if8.out_ready  = ($urandom_range(9, 0) < 5);
            if32.out_ready = ($urandom_range(9, 0) < 6);
            clk_step();
        end

        // Drain everything still in flight
        if16.in_valid = 1'b0; if8.in_valid = 1'b0; if32.in_valid = 1'b0;
        if16.out_ready = 1'b1; if8.out_ready = 1'b1; if32.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) clk_step();
        check_int("drain16", q16.size(), 0);
        check_int("drain8", q8.size(), 0);
        check_int("drain32", q32.size(), 0);
        check_int("idle_out_valid16", int'(if16.out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
